fifo_sync_param: RTL

Parametrised single-clock circular-buffer FIFO and successor to the fixed 16x8 fifo. Width, depth and flag thresholds are configurable. Accepts a write and a read in the same cycle, provides a registered read port with a one-cycle valid strobe, an occupancy count, sticky error flags with explicit clear, and a synchronous flush. Used wherever the design buffers sample or pixel streams between producer and consumer logic on one clock.

---
 rtl/fifo_sync_param_pkg.sv | 38 +++
 rtl/fifo_sync_param_if.sv | 37 +++
 rtl/fifo_sync_param_ram.sv | 38 +++
 rtl/fifo_sync_param.sv | 119 +++++++++++
 4 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
// Provides a constant-evaluable clog2, the occupancy-count width helper,
// default geometry, and parameter-legality predicates used at elaboration.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Smallest n such that 2**n >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Count must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_w(DEFAULT_DEPTH);

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int unsigned depth, input int unsigned af);
    return (af >= 1) && (af <= depth - 1);
  endfunction

  function automatic bit ae_ok(input int unsigned depth, input int unsigned ae);
    return ae <= depth - 2;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle for fifo_sync_param.
// master: producer/consumer side (drives wr, rd, flush, clr, din).
// slave : the FIFO (drives dout, valid, count and all flags).
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic             wr;
  logic             rd;
  logic             flush;
  logic             clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             almostfull;
  logic             empty;
  logic             almostempty;
  logic             over;
  logic             under;

  modport master (
    output wr, rd, flush, clr, din,
    input  dout, valid, count, full, almostfull, empty, almostempty, over, under
  );

  modport slave (
    input  wr, rd, flush, clr, din,
    output dout, valid, count, full, almostfull, empty, almostempty, over, under
  );

endinterface

// File: rtl/fifo_sync_param_ram.sv
// fifo_ram: simple dual-port WIDTH x DEPTH storage.
// Ports: clk, rst (sync active-low, clears only the read register),
//   i_we/i_waddr/i_wdata synchronous write,
//   i_re/i_raddr registered read, o_rdata holds until the next i_re.
// Array itself is not reset so it can map onto block/distributed RAM.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-address read/write returns the old word (full FIFO with rd+wr).
  always_ff @(posedge clk) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parameterised single-clock circular-buffer FIFO.
// Ports: clk, rst (synchronous, active-low), bus (fifo_sync_param_if.slave):
//   wr/rd requests, flush (discard contents), clr (clear sticky errors),
//   din in; dout registered read data with one-cycle valid strobe,
//   count occupancy, full/almostfull/empty/almostempty decoded from count,
//   sticky over/under error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sync_param_if.slave  bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 4");
  end
  if (!af_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH-1");
  end
  if (!ae_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-2");
  end

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_over;
  logic             r_under;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_over_set;
  logic             w_under_set;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is accepted when a read frees a slot this cycle.
  assign w_rd_ok = bus.rd & ~w_empty;
  assign w_wr_ok = bus.wr & (~w_full | w_rd_ok);

  // Flush swallows both requests and suppresses error reporting.
  assign w_rd_acc    = w_rd_ok & ~bus.flush;
  assign w_wr_acc    = w_wr_ok & ~bus.flush;
  assign w_over_set  = bus.wr & ~w_wr_ok & ~bus.flush;
  assign w_under_set = bus.rd & ~w_rd_ok & ~bus.flush;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (bus.din),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Pointers are AW bits wide; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      r_valid <= w_rd_acc;
    end
  end

  // A new error in the same cycle as clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_over  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_over  <= w_over_set  | (r_over  & ~bus.clr);
      r_under <= w_under_set | (r_under & ~bus.clr);
    end
  end

  assign bus.dout        = w_rdata;
  assign bus.valid       = r_valid;
  assign bus.count       = r_count;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almostfull  = (r_count >= CW'(AF_LEVEL));
  assign bus.almostempty = (r_count <= CW'(AE_LEVEL));
  assign bus.over        = r_over;
  assign bus.under       = r_under;

endmodule
